c1541_img_server: RTL and testbench

Responder end of the per-drive sector-block interface used by the 1541 track buffer. It accepts `sd_rd`/`sd_wr` block requests with an LBA and acknowledges them with `sd_ack`. For reads it streams 512 bytes into the requester's buffer; for writes it pulls 512 bytes out of that buffer. The image lives in a byte-wide backing memory (BRAM/SDRAM bridge) behind a simple req/ready port, so drive emulation runs standalone without the HPS.

---
 rtl/c1541_img_pkg.sv | 20 ++
 rtl/c1541_img_server.sv | 243 ++++++++++++++++++++++++
 tb/tb_c1541_img_server.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c1541_img_pkg.sv
// Shared types and constants for the 1541 sector-image responder.
package c1541_img_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RD_PUT,
        WR_ADDR,
        WR_LAT,
        WR_REQ,
        WR_WAIT,
        HOLD
    } img_state_t;

    localparam int SECTOR_BYTES = 512;
    localparam int BUFF_LAT     = 1;
    localparam int WR_LAT_CYC   = 2;

endpackage

// File: rtl/c1541_img_server.sv
// Responder for the per-drive sector-block interface of the 1541 track buffer.
// Serves sd_rd/sd_wr block requests from a byte-wide backing memory.
// Optional build macro: C1541_IMG_BOUNDS_EN (LBA range check against img_size).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transfer, waiting for sd_rd / sd_wr
// RD_REQ  | mem_rd strobe for the current byte
// RD_WAIT | waiting for mem_ready, read byte captured on arrival
// RD_PUT  | sd_buff_wr strobe into requester buffer (2 cycles if out of range)
// WR_ADDR | sd_buff_addr presented to requester buffer
// WR_LAT  | requester RAM latency; sd_buff_din captured on the last cycle
// WR_REQ  | mem_wr strobe with captured byte (suppressed if out of range)
// WR_WAIT | waiting for mem_ready of the write
// HOLD    | block done, sd_ack held until the request is released
module c1541_img_server
    import c1541_img_pkg::*;
#(
    parameter int MEM_AW = 24
) (
    input  logic              sd_clk,
    input  logic              reset,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    input  logic [7:0]        sd_buff_din,
    output logic              sd_buff_wr,
    input  logic              img_mounted,
    input  logic [31:0]       img_size,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err
);

    // sd_buff_din is valid BUFF_LAT cycles after the address; capture at the end of the window.
    localparam logic LAT_LAST = 1'(WR_LAT_CYC - BUFF_LAT);

    img_state_t        state, state_nxt;
    logic [8:0]        byte_idx, byte_nxt;
    logic [MEM_AW-10:0] lba_q, lba_nxt;
    logic              is_wr, is_wr_nxt;
    logic              oor, oor_nxt;
    logic              rel, rel_nxt;
    logic              phase, phase_nxt;
    logic              ack_nxt, bwr_nxt, mrd_nxt, mwr_nxt, busy_nxt, err_nxt;
    logic [8:0]        baddr_nxt;
    logic [7:0]        bdout_nxt, mdout_nxt;
    logic [MEM_AW-1:0] maddr_nxt;
    logic              lba_oor, last_byte, req_served, wr_step;
    logic [8:0]        idx_inc;

    assign idx_inc    = byte_idx + 9'd1;
    assign last_byte  = (byte_idx == 9'(SECTOR_BYTES - 1));
    // Release is judged on the request being served, so a pending request of the
    // other kind does not pin the block in HOLD.
    assign req_served = is_wr ? sd_wr : sd_rd;

`ifdef C1541_IMG_BOUNDS_EN
    assign lba_oor = (sd_lba >= img_size);
    logic unused_lba_hi;
    assign unused_lba_hi = ^sd_lba[31:MEM_AW-9];
`else
    assign lba_oor = 1'b0;
    logic unused_cfg;
    assign unused_cfg = ^{sd_lba[31:MEM_AW-9], img_size, img_mounted};
`endif

    // Next-state and next-output decode; strobes default low, everything else holds.
    always_comb begin
        state_nxt = state;
        byte_nxt  = byte_idx;
        lba_nxt   = lba_q;
        is_wr_nxt = is_wr;
        oor_nxt   = oor;
        rel_nxt   = rel;
        phase_nxt = phase;
        ack_nxt   = sd_ack;
        bwr_nxt   = 1'b0;
        mrd_nxt   = 1'b0;
        mwr_nxt   = 1'b0;
        baddr_nxt = sd_buff_addr;
        bdout_nxt = sd_buff_dout;
        maddr_nxt = mem_addr;
        mdout_nxt = mem_dout;
        wr_step   = 1'b0;
`ifdef C1541_IMG_BOUNDS_EN
        err_nxt   = err;
        if (img_mounted) err_nxt = 1'b0;
`else
        err_nxt   = 1'b0;
`endif
        if (sd_ack && !req_served) rel_nxt = 1'b1;

        case (state)
            IDLE: begin
                if (sd_rd || sd_wr) begin
                    lba_nxt   = sd_lba[MEM_AW-10:0];
                    is_wr_nxt = !sd_rd;
                    oor_nxt   = lba_oor;
                    rel_nxt   = 1'b0;
                    phase_nxt = 1'b0;
                    byte_nxt  = 9'd0;
                    ack_nxt   = 1'b1;
                    if (lba_oor) err_nxt = 1'b1;
                    if (sd_rd && lba_oor) begin
                        state_nxt = RD_PUT;
                        bwr_nxt   = 1'b1;
                        baddr_nxt = 9'd0;
                        bdout_nxt = 8'h00;
                    end else if (sd_rd) begin
                        state_nxt = RD_REQ;
                        mrd_nxt   = 1'b1;
                        maddr_nxt = {sd_lba[MEM_AW-10:0], 9'd0};
                    end else begin
                        state_nxt = WR_ADDR;
                        baddr_nxt = 9'd0;
                    end
                end
            end
            RD_REQ: state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (mem_ready) begin
                    state_nxt = RD_PUT;
                    bwr_nxt   = 1'b1;
                    baddr_nxt = byte_idx;
                    bdout_nxt = mem_din;
                end
            end
            RD_PUT: begin
                if (oor && !phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    byte_nxt  = idx_inc;
                    if (last_byte) begin
                        state_nxt = HOLD;
                    end else if (oor) begin
                        bwr_nxt   = 1'b1;
                        baddr_nxt = idx_inc;
                        bdout_nxt = 8'h00;
                    end else begin
                        state_nxt = RD_REQ;
                        mrd_nxt   = 1'b1;
                        maddr_nxt = {lba_q, idx_inc};
                    end
                end
            end
            WR_ADDR: begin
                state_nxt = WR_LAT;
                phase_nxt = 1'b0;
            end
            WR_LAT: begin
                if (phase == LAT_LAST) begin
                    state_nxt = WR_REQ;
                    phase_nxt = 1'b0;
                    mdout_nxt = sd_buff_din;
                    if (!oor) begin
                        mwr_nxt   = 1'b1;
                        maddr_nxt = {lba_q, byte_idx};
                    end
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            WR_REQ: begin
                if (oor) wr_step = 1'b1;
                else     state_nxt = WR_WAIT;
            end
            WR_WAIT: begin
                if (mem_ready) wr_step = 1'b1;
            end
            HOLD: begin
                if (rel || !req_served) begin
                    state_nxt = IDLE;
                    ack_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (wr_step) begin
            byte_nxt = idx_inc;
            if (last_byte) begin
                state_nxt = HOLD;
            end else begin
                state_nxt = WR_ADDR;
                baddr_nxt = idx_inc;
            end
        end

        busy_nxt = (state_nxt != IDLE);
    end

    // State, counter and registered outputs with synchronous reset.
    always_ff @(posedge sd_clk) begin
        if (reset) begin
            state        <= IDLE;
            byte_idx     <= 9'd0;
            lba_q        <= '0;
            is_wr        <= 1'b0;
            oor          <= 1'b0;
            rel          <= 1'b0;
            phase        <= 1'b0;
            sd_ack       <= 1'b0;
            sd_buff_wr   <= 1'b0;
            sd_buff_addr <= 9'd0;
            sd_buff_dout <= 8'h00;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
            mem_dout     <= 8'h00;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            byte_idx     <= byte_nxt;
            lba_q        <= lba_nxt;
            is_wr        <= is_wr_nxt;
            oor          <= oor_nxt;
            rel          <= rel_nxt;
            phase        <= phase_nxt;
            sd_ack       <= ack_nxt;
            sd_buff_wr   <= bwr_nxt;
            sd_buff_addr <= baddr_nxt;
            sd_buff_dout <= bdout_nxt;
            mem_rd       <= mrd_nxt;
            mem_wr       <= mwr_nxt;
            mem_addr     <= maddr_nxt;
            mem_dout     <= mdout_nxt;
            busy         <= busy_nxt;
            err          <= err_nxt;
        end
    end

endmodule

// File: tb/tb_c1541_img_server.sv
// Directed bench for c1541_img_server: backing memory model, requester buffer model,
// negedge monitor and hand-computed expectations.
module tb_c1541_img_server;
    import c1541_img_pkg::*;

    localparam int MEM_AW = 24;

    logic              sd_clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       sd_lba = '0;
    logic              sd_rd = 1'b0;
    logic              sd_wr = 1'b0;
    logic              sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic [7:0]        sd_buff_din = '0;
    logic              sd_buff_wr;
    logic              img_mounted = 1'b0;
    logic [31:0]       img_size = '0;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [7:0]        mem_dout;
    logic [7:0]        mem_din = '0;
    logic              mem_ready = 1'b0;
    logic              busy;
    logic              err;

    c1541_img_server #(.MEM_AW(MEM_AW)) dut (
        .sd_clk       (sd_clk),
        .reset        (reset),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_wr   (sd_buff_wr),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_dout     (mem_dout),
        .mem_din      (mem_din),
        .mem_ready    (mem_ready),
        .busy         (busy),
        .err          (err)
    );

    always #5 sd_clk = ~sd_clk;

    // Backing memory: unwritten byte at address a reads a[7:0] ^ a[16:9] (byte index ^ lba).
    logic [7:0]        mem [0:8191];
    bit                wv  [0:8191];
    logic              rand_mode = 1'b0;
    logic [2:0]        dly = 3'd0;
    logic              pend = 1'b0;
    logic [2:0]        cnt = 3'd0;
    logic [MEM_AW-1:0] paddr = '0;

    function automatic logic [7:0] mem_val(input logic [MEM_AW-1:0] a);
        return wv[a[12:0]] ? mem[a[12:0]] : (a[7:0] ^ a[16:9]);
    endfunction

    always @(posedge sd_clk) begin
        mem_ready <= 1'b0;
        dly <= rand_mode ? 3'($urandom_range(7, 0)) : 3'd0;
        if (pend) begin
            if (cnt == 3'd0) begin
                mem_ready <= 1'b1;
                mem_din   <= mem_val(paddr);
                pend      <= 1'b0;
            end else begin
                cnt <= cnt - 3'd1;
            end
        end else if (mem_rd || mem_wr) begin
            if (mem_wr) begin
                mem[mem_addr[12:0]] <= mem_dout;
                wv[mem_addr[12:0]]  <= 1'b1;
            end
            if (dly == 3'd0) begin
                mem_ready <= 1'b1;
                mem_din   <= mem_val(mem_addr);
            end else begin
                pend  <= 1'b1;
                cnt   <= dly - 3'd1;
                paddr <= mem_addr;
            end
        end
    end

    // Requester buffer: byte i holds ~i, registered read port.
    always @(posedge sd_clk) sd_buff_din <= ~sd_buff_addr[7:0];

    // Monitor: counts strobes and flags out-of-sequence or wrong-data bytes.
    logic [31:0] exp_lba = '0;
    logic        exp_zero = 1'b0;
    int cnt_bwr = 0, cnt_mrd = 0, cnt_mwr = 0, cnt_ack = 0, cnt_rdy = 0, cnt_both = 0;
    int bad_bwr = 0, bad_mwr = 0;
    logic [8:0] prev_b = 9'h1FF, prev_w = 9'h1FF;

    always @(negedge sd_clk) begin
        if (sd_ack)          cnt_ack  <= cnt_ack + 1;
        if (mem_ready)       cnt_rdy  <= cnt_rdy + 1;
        if (mem_rd)          cnt_mrd  <= cnt_mrd + 1;
        if (mem_rd && mem_wr) cnt_both <= cnt_both + 1;
        if (sd_buff_wr) begin
            cnt_bwr <= cnt_bwr + 1;
            if (sd_buff_addr != prev_b + 9'd1 ||
                sd_buff_dout != (exp_zero ? 8'h00 : (sd_buff_addr[7:0] ^ exp_lba[7:0])))
                bad_bwr <= bad_bwr + 1;
            prev_b <= sd_buff_addr;
        end
        if (mem_wr) begin
            cnt_mwr <= cnt_mwr + 1;
            if (mem_addr != {exp_lba[MEM_AW-10:0], prev_w + 9'd1} || mem_dout != ~mem_addr[7:0])
                bad_mwr <= bad_mwr + 1;
            prev_w <= mem_addr[8:0];
        end
        if (!sd_ack) begin
            prev_b <= 9'h1FF;
            prev_w <= 9'h1FF;
        end
    end

    int n_checks = 0, n_fail = 0;
    int s_bwr, s_mrd, s_mwr, s_ack, s_bad_b, s_bad_w, s_both;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge sd_clk);
        #1;
    endtask

    task automatic snap();
        s_bwr = cnt_bwr; s_mrd = cnt_mrd; s_mwr = cnt_mwr; s_ack = cnt_ack;
        s_bad_b = bad_bwr; s_bad_w = bad_mwr; s_both = cnt_both;
    endtask

    task automatic wait_bwr(input string tag, input int n, input int budget);
        int k = 0;
        while ((cnt_bwr - s_bwr) < n && k < budget) begin tick(); k++; end
        check(tag, 32'((cnt_bwr - s_bwr) >= n), 32'd1);
    endtask

    task automatic wait_mwr(input string tag, input int n, input int budget);
        int k = 0;
        while ((cnt_mwr - s_mwr) < n && k < budget) begin tick(); k++; end
        check(tag, 32'((cnt_mwr - s_mwr) >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin tick(); k++; end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int rdy_base;
        int k;

        // Reset state
        repeat (3) tick();
        check("rst_ack", 32'(sd_ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_strobes", 32'({sd_buff_wr, mem_rd, mem_wr}), 0);
        check("rst_buff_addr", 32'(sd_buff_addr), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_data", 32'({sd_buff_dout, mem_dout}), 0);
        reset = 1'b0;
        img_size = 32'd683;
        tick();

        // Read lba 5, request held past the end of the block
        exp_lba = 32'd5; exp_zero = 1'b0; snap();
        sd_lba = 32'd5; sd_rd = 1'b1;
        tick();
        check("rd_ack_rise", 32'(sd_ack), 1);
        check("rd_busy", 32'(busy), 1);
        wait_bwr("rd_done_tmo", 512, 2000);
        repeat (5) tick();
        check("rd_hold_ack", 32'(sd_ack), 1);
        sd_rd = 1'b0;
        tick();
        check("rd_ack_drop", 32'(sd_ack), 0);
        repeat (20) tick();
        check("rd_strobes", 32'(cnt_bwr - s_bwr), 512);
        check("rd_data_bad", 32'(bad_bwr - s_bad_b), 0);
        check("rd_mem_rd", 32'(cnt_mrd - s_mrd), 512);
        check("rd_ack_cycles", 32'(cnt_ack - s_ack), 1541);
        check("rd_no_mem_wr", 32'(cnt_mwr - s_mwr), 0);
        check("rd_err", 32'(err), 0);

        // Write lba 3, request released right after ack
        exp_lba = 32'd3; snap();
        sd_lba = 32'd3; sd_wr = 1'b1;
        tick();
        check("wr_ack_rise", 32'(sd_ack), 1);
        sd_wr = 1'b0;
        wait_idle("wr_idle_tmo", 4000);
        check("wr_mem_wr", 32'(cnt_mwr - s_mwr), 512);
        check("wr_data_bad", 32'(bad_mwr - s_bad_w), 0);
        check("wr_no_buff_wr", 32'(cnt_bwr - s_bwr), 0);
        check("wr_no_mem_rd", 32'(cnt_mrd - s_mrd), 0);
        check("wr_ack_cycles", 32'(cnt_ack - s_ack), 2561);
        bad = 0;
        for (int i = 0; i < 512; i++)
            if (mem_val(MEM_AW'(3 * 512 + i)) != 8'(~i)) bad++;
        check("wr_mem_image", 32'(bad), 0);

        // Simultaneous read and write on lba 7: read first, then write
        exp_lba = 32'd7; snap();
        sd_lba = 32'd7; sd_rd = 1'b1; sd_wr = 1'b1;
        wait_bwr("both_rd_tmo", 512, 2000);
        check("both_no_wr_yet", 32'(cnt_mwr - s_mwr), 0);
        check("both_rd_mem_rd", 32'(cnt_mrd - s_mrd), 512);
        sd_rd = 1'b0;
        wait_mwr("both_wr_tmo", 512, 4000);
        sd_wr = 1'b0;
        wait_idle("both_idle_tmo", 100);
        check("both_buff_wr", 32'(cnt_bwr - s_bwr), 512);
        check("both_rd_bad", 32'(bad_bwr - s_bad_b), 0);
        check("both_wr_bad", 32'(bad_mwr - s_bad_w), 0);
        check("both_never_rd_wr", 32'(cnt_both - s_both), 0);

        // Random memory delays, reset with a read in flight at byte 200
        exp_lba = 32'd9; rand_mode = 1'b1; snap();
        sd_lba = 32'd9; sd_rd = 1'b1;
        wait_bwr("rnd_200_tmo", 200, 4000);
        k = 0;
        while (!mem_rd && k < 20) begin tick(); k++; end
        check("rnd_mem_rd_seen", 32'(mem_rd), 1);
        rdy_base = cnt_rdy;
        reset = 1'b1; sd_rd = 1'b0;
        tick();
        check("rnd_rst_ack", 32'(sd_ack), 0);
        check("rnd_rst_busy", 32'(busy), 0);
        reset = 1'b0;
        snap();
        repeat (12) tick();
        check("rnd_late_ready", 32'(cnt_rdy - rdy_base), 1);
        check("rnd_ignored", 32'(cnt_bwr - s_bwr), 0);
        check("rnd_idle", 32'(busy), 0);
        snap();
        sd_rd = 1'b1;
        tick();
        check("rnd2_ack_rise", 32'(sd_ack), 1);
        sd_rd = 1'b0;
        wait_idle("rnd2_idle_tmo", 8000);
        check("rnd2_strobes", 32'(cnt_bwr - s_bwr), 512);
        check("rnd2_data_bad", 32'(bad_bwr - s_bad_b), 0);
        check("rnd2_mem_rd", 32'(cnt_mrd - s_mrd), 512);
        rand_mode = 1'b0;
        repeat (12) tick();

        // Read at lba == img_size
        exp_lba = 32'd683; snap();
`ifdef C1541_IMG_BOUNDS_EN
        exp_zero = 1'b1;
`else
        exp_zero = 1'b0;
`endif
        sd_lba = 32'd683; sd_rd = 1'b1;
        tick();
        check("oor_ack_rise", 32'(sd_ack), 1);
        sd_rd = 1'b0;
        wait_idle("oor_idle_tmo", 3000);
        check("oor_strobes", 32'(cnt_bwr - s_bwr), 512);
        check("oor_data_bad", 32'(bad_bwr - s_bad_b), 0);
`ifdef C1541_IMG_BOUNDS_EN
        check("oor_no_mem_rd", 32'(cnt_mrd - s_mrd), 0);
        check("oor_ack_cycles", 32'(cnt_ack - s_ack), 1025);
        check("oor_err_set", 32'(err), 1);
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        check("oor_err_clear", 32'(err), 0);
        exp_lba = 32'd700; snap();
        sd_lba = 32'd700; sd_rd = 1'b1; img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0; sd_rd = 1'b0;
        check("oor_set_wins", 32'(err), 1);
        wait_idle("oor2_idle_tmo", 3000);
        check("oor2_data_bad", 32'(bad_bwr - s_bad_b), 0);
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        check("oor2_err_clear", 32'(err), 0);
`else
        check("nochk_mem_rd", 32'(cnt_mrd - s_mrd), 512);
        check("nochk_err", 32'(err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
